// File: rtl/mux_nch_rr_reg_if.sv
// Handshake bundle for the N-channel registered mux: producer lanes in,
// single consumer out.
interface mux_nch_rr_reg_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned W   = 8
);
    localparam int unsigned SW = $clog2(NCH);

    logic [NCH*W-1:0] in_data;
    logic [NCH-1:0]   in_valid;
    logic [NCH-1:0]   in_ready;
    logic [SW-1:0]    sel;
    logic             mode;
    logic [W-1:0]     out_data;
    logic [SW-1:0]    out_ch;
    logic             out_valid;
    logic             out_ready;

    // Environment side: drives producer lanes, select/mode and consumer ready.
    modport master (
        output in_data, in_valid, sel, mode, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    // Mux side.
    modport slave (
        input  in_data, in_valid, sel, mode, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/mux_nch_rr_reg.sv
// N-channel W-bit mux with explicit-select or round-robin grant and a single
// registered output stage running at one word per cycle.
module mux_nch_rr_reg #(
    parameter int unsigned NCH = 4,
    parameter int unsigned W   = 8
) (
    input logic             clk,
    input logic             rst,
    mux_nch_rr_reg_if.slave bus
);
    localparam int unsigned SW = $clog2(NCH);

    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] rr_ptr_q, rr_ptr_d;

    logic          can_load;
    logic          grant_valid;
    logic [SW-1:0] grant;
    logic          load_en;
    logic [W-1:0]  grant_data;
    logic          hi_valid, lo_valid;
    logic [SW-1:0] hi_ch, lo_ch;

    assign can_load = ~out_valid_q | bus.out_ready;

    // Round-robin: lowest valid channel above rr_ptr wins, else lowest at or
    // below it, which is the same as scanning rr_ptr+1.. with wrap.
    always_comb begin
        hi_valid = 1'b0;
        lo_valid = 1'b0;
        hi_ch    = '0;
        lo_ch    = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) begin
                if (i > int'(rr_ptr_q)) begin
                    hi_valid = 1'b1;
                    hi_ch    = SW'(i);
                end else begin
                    lo_valid = 1'b1;
                    lo_ch    = SW'(i);
                end
            end
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        if (bus.mode) begin
            grant_valid = hi_valid | lo_valid;
            grant       = hi_valid ? hi_ch : lo_ch;
        end else begin
            // Out-of-range sel matches no channel and so never grants.
            for (int i = 0; i < int'(NCH); i++) begin
                if (int'(bus.sel) == i && bus.in_valid[i]) begin
                    grant_valid = 1'b1;
                    grant       = SW'(i);
                end
            end
        end
    end

    // Reset suppresses readiness so no producer sees a transfer that is discarded.
    assign load_en = can_load & grant_valid & ~rst;

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            bus.in_ready[i] = load_en && (int'(grant) == i);
            if (int'(grant) == i) begin
                grant_data = bus.in_data[i*W +: W];
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_en) begin
            out_data_d  = grant_data;
            out_ch_d    = grant;
            out_valid_d = 1'b1;
            rr_ptr_d    = grant;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= SW'(NCH - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;
endmodule
